// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, handshake FSM states, flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } state_e;

  // Bit positions when flags are packed into a vector by downstream units.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative logical shifter: one bit per cycle. done is high during the final step; result and
// last_out then already present the fully shifted value and the last bit shifted out, so the
// owner can capture them on that same edge.
module alu_shift_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             left,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amount,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             last_out
);

  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic             busy_q;
  logic             left_q;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;

  // One-bit shift of the work register and the bit that falls off.
  always_comb begin
    shifted = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
    out_bit = left_q ? work_q[WIDTH-1] : work_q[0];
    done    = busy_q && (cnt_q == SHW'(1));
  end

  assign result   = shifted;
  assign last_out = out_bit;

  // Load on start, then step until the counter runs out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      left_q <= 1'b0;
    end else if (start) begin
      work_q <= a;
      cnt_q  <= amount;
      busy_q <= 1'b1;
      left_q <= left;
    end else if (busy_q) begin
      work_q <= shifted;
      cnt_q  <= cnt_q - SHW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with valid/ready on both sides. Results and flags are registered and held until
// consumed; non-zero shifts are delegated to the iterative shift unit.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v
);

  state_e           state_q;
  logic [WIDTH-1:0] rd_q;
  logic             z_q, c_q, n_q, v_q;

  logic             accept;
  logic             start_shift;
  logic [SHW-1:0]   amount;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_rd;
  logic             res_c, res_v;
  logic             sh_done, sh_last;
  logic [WIDTH-1:0] sh_result;

  // Handshake: HOLD frees the input side only when the held result drains this cycle.
  always_comb begin
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StHold:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign amount      = src[SHW-1:0];
  assign start_shift = accept && is_shift_op(alu_op) && (amount != '0);
  assign out_valid   = (state_q == StHold);

  // Single-cycle result for the accepted op; shifts here only cover the amount-0 case.
  always_comb begin
    sum    = '0;
    res_rd = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    unique case (alu_op)
      OP_ADD, OP_ADC: begin
        sum    = {1'b0, a} + {1'b0, src} + {{WIDTH{1'b0}}, (alu_op == OP_ADC) && c_q};
        res_rd = sum[WIDTH-1:0];
        res_c  = sum[WIDTH];
        res_v  = (a[WIDTH-1] == src[WIDTH-1]) && (res_rd[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Underflow wraps into bit WIDTH, which is exactly the borrow.
        sum    = {1'b0, a} - {1'b0, src};
        res_rd = sum[WIDTH-1:0];
        res_c  = sum[WIDTH];
        res_v  = (a[WIDTH-1] != src[WIDTH-1]) && (res_rd[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHR, OP_SHL: res_rd = a;
      OP_XOR:         res_rd = a ^ src;
      OP_OR:          res_rd = a | src;
      OP_AND:         res_rd = a & src;
    endcase
  end

  alu_shift_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_shift),
    .left     (alu_op == OP_SHL),
    .a        (a),
    .amount   (amount),
    .done     (sh_done),
    .result   (sh_result),
    .last_out (sh_last)
  );

  // Handshake FSM plus result/flag registers; flags change only when a result is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rd_q    <= '0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHold: begin
          if (accept) begin
            if (start_shift) begin
              state_q <= StShift;
            end else begin
              rd_q    <= res_rd;
              z_q     <= (res_rd == '0);
              c_q     <= res_c;
              n_q     <= res_rd[WIDTH-1];
              v_q     <= res_v;
              state_q <= StHold;
            end
          end else if ((state_q == StHold) && out_ready) begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          if (sh_done) begin
            rd_q    <= sh_result;
            z_q     <= (sh_result == '0);
            c_q     <= sh_last;
            n_q     <= sh_result[WIDTH-1];
            v_q     <= 1'b0;
            state_q <= StHold;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd = rd_q;
  assign z  = z_q;
  assign c  = c_q;
  assign n  = n_q;
  assign v  = v_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: expected results are queued at issue and checked on delivery.
module tb_seq_alu;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef struct packed {
    logic [15:0] rd;
    logic        z;
    logic        c;
    logic        n;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [15:0] a;
  logic [15:0] src;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] rd;
  logic        z, c, n, v;

  exp_t sb[$];
  logic model_c;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .src       (src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .z         (z),
    .c         (c),
    .n         (n),
    .v         (v)
  );

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] x,
                                 input logic [15:0] y, input logic cin);
    exp_t        e;
    logic [16:0] s;
    int          amt;
    e   = '0;
    amt = int'(y[3:0]);
    case (op)
      OP_ADD, OP_ADC: begin
        s    = {1'b0, x} + {1'b0, y} + ((op == OP_ADC && cin) ? 17'd1 : 17'd0);
        e.rd = s[15:0];
        e.c  = s[16];
        e.v  = (x[15] == y[15]) && (e.rd[15] != x[15]);
      end
      OP_SUB: begin
        e.rd = x - y;
        e.c  = (x < y);
        e.v  = (x[15] != y[15]) && (e.rd[15] != x[15]);
      end
      OP_SHR: begin
        e.rd = x >> amt;
        e.c  = (amt == 0) ? 1'b0 : x[amt-1];
      end
      OP_SHL: begin
        e.rd = x << amt;
        e.c  = (amt == 0) ? 1'b0 : x[16-amt];
      end
      OP_XOR:  e.rd = x ^ y;
      OP_OR:   e.rd = x | y;
      default: e.rd = x & y;
    endcase
    e.z = (e.rd == 16'h0000);
    e.n = e.rd[15];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      fails++;
      $error("FAIL %s: observed result with empty scoreboard, expected none", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_rd"}, 32'(rd), 32'(e.rd));
      check({tag, "_z"},  32'(z),  32'(e.z));
      check({tag, "_c"},  32'(c),  32'(e.c));
      check({tag, "_n"},  32'(n),  32'(e.n));
      check({tag, "_v"},  32'(v),  32'(e.v));
    end
  endtask

  // Present an op and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int   k;
    alu_op   = op;
    a        = x;
    src      = y;
    in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 64);
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    e = model(op, x, y, model_c);
    model_c = e.c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op   = 3'bxxx;
    a        = 16'hxxxx;
    src      = 16'hxxxx;
  endtask

  // Wait for out_valid, check the accept-to-valid latency and the delivered result.
  task automatic expect_out(input string tag, input int lat);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!out_valid) check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
    end while (!out_valid && k < 64);
    check({tag, "_latency"}, 32'(k), 32'(lat));
    if (out_valid) compare_front(tag);
    else void'(sb.pop_front());
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = 3'b000;
    a         = 16'h0000;
    src       = 16'h0000;
    model_c   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rd", 32'(rd), 32'h0000);
    check("rst_z", 32'(z), 32'd1);
    check("rst_c", 32'(c), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    send(OP_ADD, 16'hFFFF, 16'h0001); expect_out("add_wrap", 1);
    send(OP_ADC, 16'h0000, 16'h0000); expect_out("adc_carry", 1);
    send(OP_SUB, 16'h0001, 16'h0002); expect_out("sub_borrow", 1);
    send(OP_ADD, 16'h7FFF, 16'h0001); expect_out("add_ovf", 1);
    send(OP_SUB, 16'h0005, 16'h0003); expect_out("sub_plain", 1);
    send(OP_OR,  16'h0F00, 16'h00F0); expect_out("or", 1);
    send(OP_SHL, 16'h8001, 16'h0004); expect_out("shl4", 5);
    send(OP_SHL, 16'hFFFF, 16'h0010); expect_out("shl0", 1);
    send(OP_SHR, 16'h8003, 16'h0002); expect_out("shr2", 3);

    // Back-pressure: result must hold while out_ready is low, then drain with no gap.
    out_ready = 1'b0;
    send(OP_XOR, 16'h00FF, 16'h0F0F);
    @(negedge clk);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    compare_front("xor");
    alu_op   = OP_AND;
    a        = 16'hF0F0;
    src      = 16'hFF00;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold_rd", 32'(rd), 32'h0FF0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    begin
      exp_t e;
      e = model(OP_AND, 16'hF0F0, 16'hFF00, model_c);
      model_c = e.c;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_out("and_b2b", 1);

    // Reset in the middle of a long shift abandons it.
    send(OP_SHR, 16'h8000, 16'h000F);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_rd", 32'(rd), 32'h0000);
    check("midrst_z", 32'(z), 32'd1);
    check("midrst_c", 32'(c), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    model_c = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    send(OP_ADD, 16'h0001, 16'h0002); expect_out("post_rst_add", 1);
    send(OP_ADC, 16'h0005, 16'h0000); expect_out("post_rst_adc", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
